// File: rtl/quadra_seq_pkg.sv
// Shared types and widths for the quadratic-interpolation sequencer.
// Holds the FSM state enum and the result saturation helper.
package quadra_seq_pkg;

   localparam int X1_W      = 7;
   localparam int X2_W      = 17;
   localparam int COEF_W    = 32;
   localparam int Y_W       = 32;
   localparam int MUL_LAT_D = 2;
   localparam int ACC_W     = COEF_W + 2;
   localparam int MB_W      = X2_W + 1;
   localparam int PROD_W    = ACC_W + MB_W;

   typedef logic [X1_W-1:0]          x1_t;
   typedef logic [X2_W-1:0]          x2_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef coef_t                    a_t;
   typedef coef_t                    b_t;
   typedef coef_t                    c_t;
   typedef logic signed [Y_W-1:0]    y_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [MB_W-1:0]   mb_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      M1,
      M2,
      DONE
   } state_t;

   typedef struct packed {
      logic sat;
      y_t   y;
   } res_t;

   // In range iff all bits from the Y sign bit upward agree.
   function automatic res_t saturate(input acc_t v);
      res_t r;
      logic [ACC_W-Y_W:0] top;
      top = v[ACC_W-1:Y_W-1];
      if ((&top) || !(|top)) begin
         r.sat = 1'b0;
         r.y   = v[Y_W-1:0];
      end else begin
         r.sat = 1'b1;
         r.y   = v[ACC_W-1] ? {1'b1, {(Y_W-1){1'b0}}}
                            : {1'b0, {(Y_W-1){1'b1}}};
      end
      return r;
   endfunction

endpackage

// File: rtl/quadra_seq_mul.sv
// Pipelined signed multiplier, LAT register stages, no handshake.
// Shared by both Horner steps of the sequencer.
module quadra_seq_mul
   import quadra_seq_pkg::*;
#(
   parameter int LAT = MUL_LAT_D
) (
   input  logic  clk,
   input  logic  rst_n,
   input  acc_t  a,
   input  mb_t   b,
   output prod_t p
);

   prod_t pipe [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= prod_t'(a) * prod_t'(b);
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign p = pipe[LAT-1];

endmodule

// File: rtl/quadra_seq.sv
// Sequencer evaluating y = (a*x2 + b)*x2 + c on one shared multiplier.
// One operation in flight; coefficients come from an external LUT.
module quadra_seq
   import quadra_seq_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_D
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [X1_W+X2_W-1:0] in_x,
   output x1_t                  lut_x1,
   input  a_t                   lut_a,
   input  b_t                   lut_b,
   input  c_t                   lut_c,
   output logic                 out_valid,
   input  logic                 out_ready,
   output y_t                   out_y,
   output logic                 out_sat,
   output logic                 busy
);

   localparam int CNT_W = $clog2(MUL_LAT + 1);

   state_t           state;
   state_t           state_nx;
   x1_t              x1_q;
   x2_t              x2_q;
   acc_t             acc;
   acc_t             b_q;
   acc_t             c_q;
   logic [CNT_W-1:0] cnt;
   logic             last;
   prod_t            prod;
   acc_t             step;
   res_t             res;
   y_t               y_q;
   logic             sat_q;

   quadra_seq_mul #(.LAT(MUL_LAT)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (acc),
      .b     ({1'b0, x2_q}),
      .p     (prod)
   );

   assign last = (cnt == CNT_W'(MUL_LAT));
   assign step = acc_t'(prod >>> X2_W) + ((state == M1) ? b_q : c_q);
   assign res  = saturate(step);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nx = FETCH;
         FETCH:                  state_nx = M1;
         M1:      if (last)      state_nx = M2;
         M2:      if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1_q  <= '0;
         x2_q  <= '0;
         acc   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         cnt   <= '0;
         y_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x1_q <= in_x[X2_W +: X1_W];
                  x2_q <= in_x[X2_W-1:0];
               end
            end
            FETCH: begin
               acc <= acc_t'(lut_a);
               b_q <= acc_t'(lut_b);
               c_q <= acc_t'(lut_c);
               cnt <= '0;
            end
            M1, M2: begin
               if (last) begin
                  acc <= step;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
         // Result is latched once and held through any output stall.
         if (state == M2 && last) begin
            y_q   <= res.y;
            sat_q <= res.sat;
         end
      end
   end

   assign in_ready  = rst_n && (state == IDLE);
   assign lut_x1    = x1_q;
   assign out_valid = (state == DONE);
   assign out_y     = y_q;
   assign out_sat   = sat_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_quadra_seq.sv
// Randomized bench for quadra_seq against a plain-arithmetic Horner model.
// Adds literal checks for LUT entry 0, saturation, latency and period.
module tb_quadra_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_x;
   logic [6:0]  lut_x1;
   logic [31:0] lut_a;
   logic [31:0] lut_b;
   logic [31:0] lut_c;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_y;
   logic        out_sat;
   logic        busy;

   logic [31:0] ta [128];
   logic [31:0] tb [128];
   logic [31:0] tc [128];

   int     vectors = 0;
   int     errors  = 0;
   bit     chk_en  = 0;
   longint cyc     = 0;
   longint acc_times [$];

   bit          m_busy;
   bit          m_done;
   int          m_t;
   logic [6:0]  m_x1;
   logic [31:0] m_y;
   logic        m_sat;
   logic [31:0] p_y;
   logic        p_sat;

   always #5 clk = ~clk;

   assign lut_a = ta[lut_x1];
   assign lut_b = tb[lut_x1];
   assign lut_c = tc[lut_x1];

   quadra_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .lut_x1    (lut_x1),
      .lut_a     (lut_a),
      .lut_b     (lut_b),
      .lut_c     (lut_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Horner evaluation with floor shifts, then clip to 32-bit signed.
   task automatic horner(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] c,
                         input logic [16:0] x2,
                         output logic [31:0] y,
                         output logic sat);
      longint acc;
      longint x;
      x   = longint'(x2);
      acc = longint'(signed'(a));
      acc = ((acc * x) >>> 17) + longint'(signed'(b));
      acc = ((acc * x) >>> 17) + longint'(signed'(c));
      if (acc > 64'sd2147483647) begin
         y = 32'h7fffffff;
         sat = 1'b1;
      end else if (acc < -64'sd2147483648) begin
         y = 32'h80000000;
         sat = 1'b1;
      end else begin
         y = acc[31:0];
         sat = 1'b0;
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0;
         m_done = 0;
         m_t    = 0;
         m_x1   = '0;
         m_y    = '0;
         m_sat  = 1'b0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1;
            m_t    = 0;
            m_x1   = in_x[23:17];
            horner(ta[m_x1], tb[m_x1], tc[m_x1],
                   in_x[16:0], p_y, p_sat);
            acc_times.push_back(cyc);
         end
      end else if (!m_done) begin
         m_t++;
         if (m_t == 7) begin
            m_done = 1;
            m_y    = p_y;
            m_sat  = p_sat;
         end
      end else if (out_ready) begin
         m_busy = 0;
         m_done = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, rst_n && !m_busy);
         chk("busy", busy, m_busy);
         chk("out_valid", out_valid, m_done);
         chk("lut_x1", lut_x1, m_x1);
         chk("out_y", out_y, m_y);
         chk("out_sat", out_sat, m_sat);
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", in_ready, 1);
      #1;
   endtask

   task automatic run_one(input logic [6:0] x1,
                          input logic [16:0] x2,
                          input logic [31:0] ey,
                          input logic esat);
      int lat;
      bit seen;
      wait_idle();
      in_valid = 1'b1;
      in_x = {x1, x2};
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      seen = 0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         seen = out_valid;
      end
      chk("latency", lat, 7);
      chk("lit_y", out_y, ey);
      chk("lit_sat", out_sat, esat);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         ta[i] = $urandom;
         tb[i] = $urandom;
         tc[i] = $urandom;
      end
      ta[0] = 32'h0;
      tb[0] = 32'h10F876CC;
      tc[0] = 32'h16a09e66;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_x = '0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_busy", busy, 0);
      chk_en = 1;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);

      run_one(7'd0, 17'h0, 32'h16a09e66, 1'b0);
      run_one(7'd0, 17'h10000, 32'h1F1CD9CC, 1'b0);

      ta[127] = 32'h7fffffff;
      tb[127] = 32'h7fffffff;
      tc[127] = 32'h7fffffff;
      run_one(7'h7f, 17'h1ffff, 32'h7fffffff, 1'b1);
      wait_idle();
      ta[127] = 32'h80000000;
      tb[127] = 32'h80000000;
      tc[127] = 32'h80000000;
      run_one(7'h7f, 17'h1ffff, 32'h80000000, 1'b1);
      wait_idle();
      ta[127] = $urandom;
      tb[127] = $urandom;
      tc[127] = $urandom;

      // Output stall: held result and blocked input are checked per cycle.
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_x = {7'd9, 17'h1234f};
      @(posedge clk);
      #1 in_x = 24'($urandom);
      for (int i = 0; i < 40 && !out_valid; i++) begin
         @(negedge clk);
         #1;
      end
      chk("stall_reach", out_valid, 1);
      repeat (20) @(negedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Reset inside M1 drops the operation.
      in_valid = 1'b1;
      in_x = {7'd5, 17'h0abcd};
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      run_one(7'd0, 17'h0, 32'h16a09e66, 1'b0);
      wait_idle();

      // Back-to-back with in_valid held high through the output handshake.
      acc_times.delete();
      in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         in_x = 24'($urandom);
         @(negedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("b2b_count", acc_times.size() >= 6, 1);
      for (int i = 1; i < acc_times.size(); i++)
         chk("period", acc_times[i] - acc_times[i-1], 9);
      wait_idle();

      for (int i = 0; i < 500; i++) begin
         logic [6:0]  x1;
         logic [16:0] x2;
         @(negedge clk);
         #1;
         x1 = ($urandom_range(0, 3) == 0) ? 7'h7f : 7'($urandom);
         case ($urandom_range(0, 3))
            0:       x2 = 17'h0;
            1:       x2 = 17'h1ffff;
            default: x2 = 17'($urandom);
         endcase
         in_valid = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_x = {x1, x2};
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      @(negedge clk);
      chk_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
